muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit with architectural Hi/Lo registers.
- Replaces the single-cycle combinational multiplier beside the main ALU in the CPU datapath.
- Adds signed and unsigned multiply, signed and unsigned divide, and MTHI/MTLO writes.
- The controller hands over an operation with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and Hi/Lo register width in bits. Legal values are 4 or more.
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
- A  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data; sampled on the accepting edge.
- B  input  WIDTH  multiplier or divisor; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result is committed to Hi/Lo.
- divByZero  output  1  set when a divide had B=0.
- Hi  output  WIDTH  high product word, or remainder.
- Lo  output  WIDTH  low product word, or quotient.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): Hi=0, Lo=0, busy=0, done=0, divByZero=0, state IDLE, counter 0. An in-flight operation is discarded.
- States: IDLE, RUN.
- Accept: on an edge with state IDLE and start=1 and a non-reserved op:
  - A, B and op are latched.
  - done and divByZero are cleared.
  - Reserved op, or start while busy=1: ignored. No state change, outputs unchanged.
- MTHI/MTLO:
  - On the accepting edge, Hi (or Lo) <= A and done=1 for the following cycle.
  - busy never rises. The other register is unchanged.
- Divide with B=0 (DIVU or DIV):
  - On the accepting edge, divByZero=1 and done=1. Stay in IDLE.
  - Hi/Lo unchanged. divByZero holds until the next accepted start.
- Multiply and valid divide:
  - Go to RUN and set busy=1. Signed ops take the magnitudes of A and B and record the result signs.
  - RUN performs one radix-2 iteration per edge. Multiply is shift-add into a 2*WIDTH accumulator; divide is restoring shift-subtract.
  - After exactly WIDTH iterations, on the WIDTH-th edge after acceptance:
    - Hi/Lo are written with the sign-corrected result.
    - busy=0, done=1 for one cycle, state IDLE.
  - A new start may be accepted on the edge where done is shown.
- Latency: done is visible WIDTH clock cycles after the accepting edge. Hi/Lo hold their old values for the whole RUN period, so reads during busy return the previous result.
- Multiply results: {Hi,Lo} is the full 2*WIDTH product. MULT negates the product when the operand signs differ.
- Divide results: Lo = quotient, truncated toward zero; Hi = remainder, with the sign of the dividend.
- Overflow case: DIV of the most-negative value by -1 gives Lo = most-negative (wraps), Hi=0, and no flag.
- No inputs are sampled during RUN; A and B may change freely.

Test Plan:
- MULTU with A=B=0xFFFFFFFF (WIDTH=32) -> busy for 32 cycles, then done pulse, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT with A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then DIV with A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU with A=100, B=0 after an MTHI of 0x1234 -> done and divByZero next cycle, Hi=0x1234 and Lo unchanged, busy stays 0. The next accepted start clears divByZero.
- DIV with A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, divByZero=0.
- Start DIVU 10/3, then pulse start with MULTU 2*2 at cycle 5 -> second request ignored; Hi=1, Lo=3 after 32 cycles.
- Assert reset at cycle 10 of a MULTU -> Hi=Lo=0, busy=0 immediately. A subsequent MTLO of 0xABCD gives Lo=0xABCD and done one cycle later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Purpose: multi-cycle signed/unsigned multiply and divide unit holding the architectural Hi/Lo registers.
// Latency: MULT/DIV commit WIDTH cycles after the accepting edge; MTHI/MTLO and divide-by-zero complete on the accepting edge.
// Backpressure: busy is high during RUN, and any start seen while busy (or with a reserved op) is dropped, not queued.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op, A, B     request strobe, opcode (MULTU/MULT/DIVU/DIV/MTHI/MTLO) and operands
//   busy, done          iteration in progress / one-cycle commit pulse
//   divByZero           sticky flag for a divide with B=0, cleared by the next accepted start
//   Hi, Lo              product high/low words, or remainder/quotient
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, stateNxt;
    logic [CNT_W-1:0]     cnt, cntNxt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / growing quotient}.
    logic [2*WIDTH-1:0]   acc, accNxt;
    logic [WIDTH-1:0]     magB, magBNxt;
    logic                 isDiv, isDivNxt;
    logic                 negQ, negQNxt;   // product sign (multiply) or quotient sign (divide)
    logic                 negR, negRNxt;   // remainder takes the dividend's sign
    logic [WIDTH-1:0]     hiNxt, loNxt;
    logic                 doneNxt, dbzNxt;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     magA, magBIn;
    logic                 signedOp;

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            magB      <= '0;
            isDiv     <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            acc       <= accNxt;
            magB      <= magBNxt;
            isDiv     <= isDivNxt;
            negQ      <= negQNxt;
            negR      <= negRNxt;
            Hi        <= hiNxt;
            Lo        <= loNxt;
            done      <= doneNxt;
            divByZero <= dbzNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        accNxt   = acc;
        magBNxt  = magB;
        isDivNxt = isDiv;
        negQNxt  = negQ;
        negRNxt  = negR;
        hiNxt    = Hi;
        loNxt    = Lo;
        doneNxt  = 1'b0;
        dbzNxt   = divByZero;
        prod     = '0;

        // op[0] marks the signed variants of MULT/DIV.
        signedOp = op[0];
        magA     = (signedOp && A[WIDTH-1]) ? -A : A;
        magBIn   = (signedOp && B[WIDTH-1]) ? -B : B;

        // Shift-add: add the multiplicand to the upper half when the current multiplier bit is set.
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, magB};
        // Restoring divide: shift in the next dividend bit and try to subtract; the top bit is the borrow.
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, magB};

        if (!isDiv) begin
            step = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end

        unique case (state)
            IDLE: begin
                if (start && !(op[2] && op[1])) begin
                    dbzNxt = 1'b0;
                    if (op == OP_MTHI) begin
                        hiNxt   = A;
                        doneNxt = 1'b1;
                    end else if (op == OP_MTLO) begin
                        loNxt   = A;
                        doneNxt = 1'b1;
                    end else if (op[1] && (B == '0)) begin
                        dbzNxt  = 1'b1;
                        doneNxt = 1'b1;
                    end else begin
                        // Multiplication commutes, so both ops load |A| into the
                        // low half and keep |B| as the add/subtract operand.
                        stateNxt = RUN;
                        cntNxt   = '0;
                        accNxt   = {{WIDTH{1'b0}}, magA};
                        magBNxt  = magBIn;
                        isDivNxt = op[1];
                        negQNxt  = signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
                        negRNxt  = signedOp && A[WIDTH-1];
                    end
                end
            end
            RUN: begin
                accNxt = step;
                cntNxt = cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                    doneNxt  = 1'b1;
                    if (isDiv) begin
                        // The most-negative / -1 case lands here with negQ=0 and a
                        // quotient of 2^(WIDTH-1), which reads back as the wrapped value.
                        loNxt = negQ ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                        hiNxt = negR ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
                    end else begin
                        prod  = negQ ? -step : step;
                        hiNxt = prod[2*WIDTH-1:WIDTH];
                        loNxt = prod[WIDTH-1:0];
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, divByZero;
    logic [31:0] Hi, Lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .divByZero(divByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a request at the falling edge, let one rising edge sample it,
    // then drop start; returns at posedge+1.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prevHi, prevLo;
        logic        prevDbz;
        int          n;

        vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
        vt[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32};
        vt[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
        vt[3]  = '{3'b100, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFD, 1'b0, 0};
        vt[4]  = '{3'b010, 32'd100,      32'h00000000, 32'h00001234, 32'hFFFFFFFD, 1'b1, 0};
        vt[5]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
        vt[6]  = '{3'b010, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 32};
        vt[7]  = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
        vt[8]  = '{3'b001, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018, 1'b0, 32};
        vt[9]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 32};
        vt[10] = '{3'b101, 32'h0000ABCD, 32'h00000000, 32'h00000001, 32'h0000ABCD, 1'b0, 0};
        vt[11] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32};
        vt[12] = '{3'b011, 32'd5,        32'h00000000, 32'h40000000, 32'h00000000, 1'b1, 0};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        #3;
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", divByZero, 0);
        @(negedge clk);
        reset = 1'b0;

        prevHi  = '0;
        prevLo  = '0;
        prevDbz = 1'b0;

        // Even rows idle two cycles first; odd rows launch in the done cycle
        // of the previous row, exercising back-to-back acceptance.
        for (int i = 0; i < 13; i++) begin
            if (i % 2 == 0) repeat (2) @(negedge clk);
            check($sformatf("row%0d_dbz_hold", i), divByZero, prevDbz);
            launch(vt[i].op, vt[i].a, vt[i].b);
            check($sformatf("row%0d_busy_acc", i), busy, vt[i].lat != 0);
            check($sformatf("row%0d_done_acc", i), done, vt[i].lat == 0);
            n = 0;
            while (!done && n < 200) begin
                @(posedge clk);
                #1;
                n++;
                if (n == 5) begin
                    check($sformatf("row%0d_hold_hi", i), Hi, prevHi);
                    check($sformatf("row%0d_hold_lo", i), Lo, prevLo);
                    check($sformatf("row%0d_busy_run", i), busy, 1);
                end
            end
            check($sformatf("row%0d_latency", i), n, vt[i].lat);
            check($sformatf("row%0d_busy_done", i), busy, 0);
            check($sformatf("row%0d_hi", i), Hi, vt[i].hi);
            check($sformatf("row%0d_lo", i), Lo, vt[i].lo);
            check($sformatf("row%0d_dbz", i), divByZero, vt[i].dbz);
            prevHi  = vt[i].hi;
            prevLo  = vt[i].lo;
            prevDbz = vt[i].dbz;
        end

        // Reserved opcode: nothing is accepted, so the sticky flag survives.
        launch(3'b110, 32'h5555AAAA, 32'h1);
        check("rsv_busy", busy, 0);
        check("rsv_done", done, 0);
        check("rsv_dbz", divByZero, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rsv_done_later", done, 0);
        check("rsv_hi", Hi, prevHi);
        check("rsv_lo", Lo, prevLo);

        // Start while busy is ignored: DIVU 10/3, then MULTU 2*2 at cycle 5.
        launch(3'b010, 32'd10, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        a     = 32'd2;
        b     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", busy, 1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ign_latency", 5 + n, 32);
        check("ign_hi", Hi, 1);
        check("ign_lo", Lo, 3);
        check("ign_dbz_cleared", divByZero, 0);
        repeat (2) @(posedge clk);
        #1;
        check("ign_no_replay_busy", busy, 0);
        check("ign_no_replay_lo", Lo, 3);

        // Reset mid-operation discards the multiply and clears Hi/Lo at once.
        launch(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_hi", Hi, 0);
        check("mrst_lo", Lo, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        launch(3'b101, 32'h0000ABCD, 32'h0);
        check("mtlo_done", done, 1);
        check("mtlo_lo", Lo, 32'h0000ABCD);
        check("mtlo_hi", Hi, 0);
        check("mtlo_busy", busy, 0);
        @(posedge clk);
        #1;
        check("mtlo_done_pulse", done, 0);
        repeat (30) @(posedge clk);
        #1;
        check("mrst_no_late_commit", Lo, 32'h0000ABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
